// File: rtl/seq_stage_ctrl.sv
// rtl/seq_stage_ctrl.sv - Y86-64 sequential-datapath stage sequencer with CC, status and retire count
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [3:0]       icode,
    input  logic [2:0]       cf_in,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       cc_out,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    stat_nx;
    logic [3:0]    icode_q;
    logic [TW-1:0] tmo_cnt;
    logic          is_mem_op;

    // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
    always_comb begin
        is_mem_op = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_op = 1'b1;
            default:                            is_mem_op = 1'b0;
        endcase
    end

    // State register and processor status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            stat  <= STAT_AOK;
        end else begin
            state <= state_nx;
            stat  <= stat_nx;
        end
    end

    // Next-state and fault-status decode
    always_comb begin
        state_nx = state;
        stat_nx  = stat;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (instr_valid) begin
                    if (imem_error) begin
                        stat_nx  = STAT_ADR;
                        state_nx = S_HALT;
                    end else if (icode > 4'hB) begin
                        stat_nx  = STAT_INS;
                        state_nx = S_HALT;
                    end else if (icode == 4'h0) begin
                        stat_nx  = STAT_HLT;
                        state_nx = S_HALT;
                    end else begin
                        state_nx = S_DECODE;
                    end
                end
            end
            S_DECODE:  state_nx = S_EXECUTE;
            S_EXECUTE: state_nx = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem_op) begin
                    state_nx = S_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_nx  = STAT_ADR;
                        state_nx = S_HALT;
                    end else begin
                        state_nx = S_WRITEBACK;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    stat_nx  = STAT_ADR;
                    state_nx = S_HALT;
                end
            end
            S_WRITEBACK: state_nx = S_PCUPD;
            S_PCUPD:     state_nx = S_FETCH;
            S_HALT:      state_nx = S_HALT;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Stage enables are registered from the next state so each one is high exactly while its stage is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_en  <= 1'b0;
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            mem_en    <= 1'b0;
            wb_en     <= 1'b0;
            pc_en     <= 1'b0;
        end else begin
            fetch_en  <= (state_nx == S_FETCH);
            decode_en <= (state_nx == S_DECODE);
            exec_en   <= (state_nx == S_EXECUTE);
            mem_en    <= (state_nx == S_MEMORY) && is_mem_op;
            wb_en     <= (state_nx == S_WRITEBACK);
            pc_en     <= (state_nx == S_PCUPD);
        end
    end

    // Latch icode on the accepted fetch cycle so later stages ignore fetch-bus changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icode_q <= 4'h0;
        end else if (state == S_FETCH && instr_valid) begin
            icode_q <= icode;
        end
    end

    // Condition codes are written only by OPq as it leaves EXECUTE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_out <= 3'b001;
        end else if (state == S_EXECUTE && icode_q == 4'h6) begin
            cc_out <= cf_in;
        end
    end

    // Memory wait counter; held at zero outside MEMORY so every entry starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != S_MEMORY) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Retire count advances once per completed instruction, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (state == S_PCUPD) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    assign busy = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb/tb_seq_stage_ctrl.sv - randomized self-checking bench for seq_stage_ctrl
module tb_seq_stage_ctrl;

    localparam int MT = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          instr_valid = 1'b0;
    logic          imem_error = 1'b0;
    logic [3:0]    icode = 4'h0;
    logic [2:0]    cf_in = 3'b000;
    logic          mem_ready = 1'b0;
    logic          dmem_error = 1'b0;
    logic          fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic [2:0]    cc_out;
    logic [2:0]    stat;
    logic          busy;
    logic [CW-1:0] instr_count;

    seq_stage_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid),
        .imem_error(imem_error), .icode(icode), .cf_in(cf_in),
        .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en),
        .cc_out(cc_out), .stat(stat), .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]    m_cc;
    logic [2:0]    m_stat;
    logic [CW-1:0] m_count;
    bit            m_halted;

    typedef struct {
        logic [5:0] en;
        bit         iv;
        bit         mr;
    } step_t;

    step_t steps[$];

    function automatic logic [5:0] en_vec();
        return {pc_en, wb_en, mem_en, exec_en, decode_en, fetch_en};
    endfunction

    function automatic bit mem_op(input logic [3:0] ic);
        return (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        imem_error = 1'b0; dmem_error = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_cc = 3'b001; m_stat = 3'd1; m_count = '0; m_halted = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Run one instruction from FETCH; rd = cycles before mem_ready (>= MT means never)
    task automatic run_instr(input logic [3:0] ic, input logic [2:0] cf, input int fw,
                             input int rd, input bit imerr, input bit dmerr);
        step_t s;
        bit fault;
        bit fetch_fault;
        logic [2:0] fstat;
        int n;
        steps.delete();
        fault = 0; fetch_fault = 0; fstat = 3'd1;
        for (int i = 0; i <= fw; i++) begin
            s.en = 6'b000001; s.iv = (i == fw); s.mr = 0; steps.push_back(s);
        end
        if (imerr)            begin fault = 1; fstat = 3'd3; end
        else if (ic > 4'hB)   begin fault = 1; fstat = 3'd4; end
        else if (ic == 4'h0)  begin fault = 1; fstat = 3'd2; end
        fetch_fault = fault;
        if (!fault) begin
            s.iv = 0; s.mr = 0;
            s.en = 6'b000010; steps.push_back(s);
            s.en = 6'b000100; steps.push_back(s);
            if (mem_op(ic)) begin
                n = (rd < MT) ? rd + 1 : MT;
                for (int i = 0; i < n; i++) begin
                    s.en = 6'b001000; s.mr = (i == rd); steps.push_back(s);
                end
                s.mr = 0;
                if (rd >= MT || dmerr) begin fault = 1; fstat = 3'd3; end
            end else begin
                s.en = 6'b000000; steps.push_back(s);
            end
            if (!fault) begin
                s.en = 6'b010000; steps.push_back(s);
                s.en = 6'b100000; steps.push_back(s);
            end
        end
        if (!fetch_fault && ic == 4'h6) m_cc = cf;
        if (fault) begin m_stat = fstat; m_halted = 1; end
        else m_count = m_count + 1'b1;

        cf_in = cf;
        dmem_error = dmerr;
        foreach (steps[k]) begin
            @(negedge clk);
            n_checks++;
            if (en_vec() !== steps[k].en || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL step ic=%h k=%0d en=%b busy=%b expected en=%b busy=1", ic, k, en_vec(), busy, steps[k].en);
            end
            instr_valid = steps[k].iv;
            icode       = steps[k].iv ? ic : 4'($urandom_range(0, 15));
            imem_error  = steps[k].iv ? imerr : 1'($urandom_range(0, 1));
            mem_ready   = steps[k].mr;
        end
        @(negedge clk);
        instr_valid = 1'b0; mem_ready = 1'b0; imem_error = 1'b0;
        n_checks++;
        if (en_vec() !== (fault ? 6'b000000 : 6'b000001) || busy !== !fault ||
            stat !== m_stat || cc_out !== m_cc || instr_count !== m_count) begin
            n_fail++;
            $display("FAIL end ic=%h en=%b busy=%b stat=%0d cc=%b cnt=%0d expected fault=%0d stat=%0d cc=%b cnt=%0d",
                     ic, en_vec(), busy, stat, cc_out, instr_count, fault, m_stat, m_cc, m_count);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (en_vec() !== 6'b0 || cc_out !== 3'b001 || stat !== 3'd1 || instr_count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset en=%b cc=%b stat=%0d cnt=%0d busy=%b expected 0 001 1 0 0",
                     en_vec(), cc_out, stat, instr_count, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fetch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold busy=%b fetch_en=%b expected 0 0", busy, fetch_en);
        end
    endtask

    task automatic test_opq();
        apply_reset();
        do_start();
        run_instr(4'h6, 3'b010, 0, 0, 0, 0);
        n_checks++;
        if (cc_out !== 3'b010 || instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL opq cc=%b cnt=%0d expected 010 1", cc_out, instr_count);
        end
    endtask

    task automatic test_cmov();
        run_instr(4'h2, 3'b100, 0, 0, 0, 0);
        n_checks++;
        if (cc_out !== 3'b010 || instr_count !== 4'd2) begin
            n_fail++;
            $display("FAIL cmov cc=%b cnt=%0d expected 010 2", cc_out, instr_count);
        end
    endtask

    task automatic test_mem_wait();
        run_instr(4'h5, 3'b111, 0, 3, 0, 0);
        run_instr(4'h8, 3'b000, 2, MT - 1, 0, 0);
        run_instr(4'h9, 3'b000, 1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr(4'hA, 3'b011, 0, MT + 4, 0, 0);
        repeat (3) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (stat !== 3'd3 || busy !== 1'b0 || en_vec() !== 6'b0) begin
            n_fail++;
            $display("FAIL timeout_halt stat=%0d busy=%b en=%b expected 3 0 0", stat, busy, en_vec());
        end
    endtask

    task automatic test_faults();
        logic [3:0] ics [3];
        bit         ims [3];
        logic [2:0] sts [3];
        ics = '{4'h0, 4'hC, 4'h3}; ims = '{0, 0, 1}; sts = '{3'd2, 3'd4, 3'd3};
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            do_start();
            run_instr(4'h1, 3'b000, 0, 0, 0, 0);
            run_instr(ics[t], 3'b110, 1, 0, ims[t], 0);
            repeat (4) begin
                @(negedge clk);
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (stat !== sts[t] || instr_count !== 4'd1 || busy !== 1'b0 || fetch_en !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_%0d stat=%0d cnt=%0d busy=%b fetch_en=%b expected %0d 1 0 0",
                         t, stat, instr_count, busy, fetch_en, sts[t]);
            end
        end
        apply_reset();
        do_start();
        run_instr(4'h4, 3'b000, 0, 2, 0, 1);
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        do_start();
        run_instr(4'h6, 3'b110, 0, 0, 0, 0);
        @(negedge clk);
        instr_valid = 1'b1; icode = 4'h5;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mem_wait mem_en=%b expected 1", mem_en);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (en_vec() !== 6'b0 || cc_out !== 3'b001 || stat !== 3'd1 || instr_count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset en=%b cc=%b stat=%0d cnt=%0d busy=%b expected 0 001 1 0 0",
                     en_vec(), cc_out, stat, instr_count, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_cc = 3'b001; m_stat = 3'd1; m_count = '0; m_halted = 0;
        do_start();
        run_instr(4'hB, 3'b000, 0, 1, 0, 0);
        run_instr(4'h6, 3'b101, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] ic;
        int rd;
        apply_reset();
        do_start();
        for (int i = 0; i < 60; i++) begin
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
            rd = ($urandom_range(0, 7) == 0) ? MT + 2 : $urandom_range(0, 5);
            run_instr(ic, 3'($urandom_range(0, 7)), $urandom_range(0, 2), rd,
                      ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
            if (m_halted) begin
                apply_reset();
                do_start();
            end
        end
    endtask

    initial begin
        test_reset();
        test_opq();
        test_cmov();
        test_mem_wait();
        test_timeout();
        test_faults();
        test_reset_mid_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
